fp_window_accum: RTL
====================

# fp_window_accum

Downstream consumer of the 12-bit two's-complement to 8-bit floating-point converter. It takes the converter's (s, e, f) output one sample at a time with a valid/ready handshake and decodes each sample back to a signed linear value, value = (-1)^s · f · 2^e. It sums a fixed window of N_SAMPLES values into a saturating signed accumulator and presents each window sum on a valid/ready output port.

## Interface
- N_SAMPLES, default 8: samples per window; legal range 2..256.
- ACC_W, default 16: accumulator and sum width in bits, signed; legal range 12..24.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- s  in  1  sample sign; 1 means negative.
- e  in  3  sample exponent.
- f  in  4  sample significand.
- in_valid  in  1  s/e/f hold a sample.
- in_ready  out  1  block accepts the sample this cycle; combinational.
- sum  out  ACC_W  signed window sum; held while sum_valid is high.
- sum_valid  out  1  sum is presented.
- sum_ready  in  1  downstream accepts sum.
- sat  out  1  at least one saturation occurred in the presented window; qualified by sum_valid.

## Operation
- **Accept:** a sample is accepted on a rising edge where in_valid && in_ready.
- **Decode stage (D).** One register: dec (12-bit signed) and dec_full.
  - Magnitude = f << e, range 0..1920.
  - dec = s ? -magnitude : magnitude.
  - s=1 with f=0 (negative zero) decodes to 0.
- **Accumulate stage (A).** Holds acc (ACC_W signed), cnt (0..N_SAMPLES-1) and window flag wsat.
  - last = (cnt == N_SAMPLES-1).
  - advance = dec_full && !(last && sum_valid && !sum_ready).
  - in_ready = !dec_full || advance.
- **Non-last advance:**
  - acc <= satadd(acc, dec).
  - cnt <= cnt+1.
  - wsat <= wsat | ovf.
- **Last advance:**
  - sum <= satadd(acc, dec).
  - sat <= wsat | ovf.
  - sum_valid <= 1.
  - acc, cnt and wsat all cleared to 0.
- **satadd:** exact signed add.
  - Result above 2^(ACC_W-1)-1 clamps to that value and sets ovf.
  - Result below -2^(ACC_W-1) clamps to that value and sets ovf.
  - Saturation only occurs when ACC_W < 12 + clog2(N_SAMPLES).
- **D register update:**
  - Loaded on accept, including in the same cycle it advances.
  - dec_full cleared when it advances without a new accept.
  - Unchanged when stalled.
- **Output FSM, OUT_IDLE / OUT_HOLD:**
  - OUT_IDLE -> OUT_HOLD on last advance.
  - OUT_HOLD -> OUT_IDLE on sum_ready with no last advance in the same cycle.
  - OUT_HOLD with sum_ready and a last advance in the same cycle: stays OUT_HOLD and loads the new sum/sat. The old sum counts as consumed.
  - sum_valid = (state == OUT_HOLD).
- **Stall:** only a completed-window sum that has not been consumed blocks the pipe. Non-last samples always advance, so up to one sample (the last of the next window) waits in D.
- **Reset mid-operation:** all state is discarded immediately. That covers any partial window, the D sample and any pending sum. No partial sum is emitted.

## Timing
- **Reset values:**
  - in_ready = 1.
  - sum_valid = 0, sum = 0, sat = 0.
  - acc = 0, cnt = 0, dec_full = 0, state = OUT_IDLE.
- **Latency:** a sample accepted at edge k enters acc (or sum) at edge k+1.
  - When the last sample of a window is accepted at edge k, sum_valid is high after edge k+1.
  - This holds whenever the output is idle or sum_ready is high.
- **Throughput:** one sample per cycle when sum_ready is held high, with no bubbles at window boundaries.
- **Handshake paths:** in_ready depends combinationally on sum_ready, sum_valid and internal state only, never on in_valid. sum, sat and sum_valid are registered.
- **Data stability:** sum and sat are stable for as long as sum_valid && !sum_ready.

## Test plan
- **Reset:** assert rst_n=0 asynchronously mid-cycle -> all outputs at reset values immediately; in_ready=1 after release.
- **Basic window:** N_SAMPLES=4, ACC_W=16, sum_ready=1; back-to-back samples (0,0,15), (0,1,8), (1,0,3), (0,7,15) -> sum=1948, sat=0, sum_valid high exactly one cycle, asserted one edge after the 4th accept.
- **Negative zero and negatives:** N_SAMPLES=4; samples (1,0,0), (1,7,15), (1,2,1), (0,0,0) -> sum=-1924, sat=0.
- **Saturation:** ACC_W=12, N_SAMPLES=4.
  - 4×(0,7,15) -> sum=2047, sat=1.
  - Next window 4×(1,7,15) -> sum=-2048, sat=1.
  - Following window 4×(0,0,1) -> sum=4, sat=0 (flag is per window).
- **Backpressure:** N_SAMPLES=2, sum_ready=0, stream 4 samples of (0,0,1) continuously.
  - First sum=2 is held; 4th sample waits in D; in_ready=0.
  - Pulse sum_ready for 1 cycle -> sum becomes 2 again (second window) in the same cycle handoff, sum_valid stays high, in_ready returns to 1.
- **Reset mid-window:** N_SAMPLES=4; accept 2 samples (0,3,5), then pulse rst_n low, then accept 4×(0,0,2) -> sum=8, no earlier sum emitted.

Source files
------------

// File: rtl/fp_window_accum.sv
// fp_window_accum: decodes (s,e,f) samples to signed linear values and
// sums fixed windows of N_SAMPLES into a saturating signed accumulator.
// Ports: clk, rst_n (async, active-low); s/e/f + in_valid/in_ready sample
// input; sum/sat + sum_valid/sum_ready window-sum output.
module fp_window_accum #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s,
    input  logic [2:0]              e,
    input  logic [3:0]              f,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    sat
);

    localparam int CW = $clog2(N_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        OUT_IDLE,
        OUT_HOLD
    } out_state_t;

    out_state_t state, state_d;

    logic signed [11:0]      dec_q;
    logic                    dec_full;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           cnt;
    logic                    wsat;

    logic [11:0]             mag;
    logic signed [11:0]      dec_in;
    logic signed [ACC_W:0]   add_full;
    logic signed [ACC_W-1:0] add_sat;
    logic                    ovf;
    logic                    last;
    logic                    advance;
    logic                    last_adv;
    logic                    accept;

    // Negative zero falls out naturally: -0 == 0.
    always_comb begin
        mag    = 12'(f) << e;
        dec_in = s ? -$signed(mag) : $signed(mag);
    end

    // One guard bit is enough: both operands fit in ACC_W bits.
    always_comb begin
        add_full = {acc[ACC_W-1], acc} + {{(ACC_W-11){dec_q[11]}}, dec_q};
        ovf      = add_full[ACC_W] ^ add_full[ACC_W-1];
        if (ovf) begin
            add_sat = add_full[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_sat = add_full[ACC_W-1:0];
        end
    end

    // Only a completed window with an unconsumed sum may stall the pipe.
    always_comb begin
        sum_valid = (state == OUT_HOLD);
        last      = (cnt == CNT_LAST);
        advance   = dec_full && !(last && sum_valid && !sum_ready);
        last_adv  = advance && last;
        in_ready  = !dec_full || advance;
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q    <= '0;
            dec_full <= 1'b0;
        end else if (accept) begin
            dec_q    <= dec_in;
            dec_full <= 1'b1;
        end else if (advance) begin
            dec_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            wsat <= 1'b0;
            sum  <= '0;
            sat  <= 1'b0;
        end else if (advance) begin
            if (last) begin
                sum  <= add_sat;
                sat  <= wsat | ovf;
                acc  <= '0;
                cnt  <= '0;
                wsat <= 1'b0;
            end else begin
                acc  <= add_sat;
                cnt  <= cnt + 1'b1;
                wsat <= wsat | ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A new sum arriving on the consuming edge keeps the port in HOLD.
    always_comb begin
        state_d = state;
        unique case (state)
            OUT_IDLE: begin
                if (last_adv) begin
                    state_d = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (last_adv) begin
                    state_d = OUT_HOLD;
                end else if (sum_ready) begin
                    state_d = OUT_IDLE;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

endmodule
